// File: rtl/vred_pkg.sv
// Shared constants, beat tag type and identity helpers for the vector reduction unit.
package vred_pkg;

    localparam int unsigned VRED_OPSEL_W = 3;
    localparam int unsigned VRED_SEW_W   = 2;

    // Reduction operation codes
    localparam logic [VRED_OPSEL_W-1:0] VRED_SUM  = 3'd0;
    localparam logic [VRED_OPSEL_W-1:0] VRED_MINU = 3'd1;
    localparam logic [VRED_OPSEL_W-1:0] VRED_MIN  = 3'd2;
    localparam logic [VRED_OPSEL_W-1:0] VRED_MAXU = 3'd3;
    localparam logic [VRED_OPSEL_W-1:0] VRED_MAX  = 3'd4;
    localparam logic [VRED_OPSEL_W-1:0] VRED_AND  = 3'd5;
    localparam logic [VRED_OPSEL_W-1:0] VRED_OR   = 3'd6;
    localparam logic [VRED_OPSEL_W-1:0] VRED_XOR  = 3'd7;

    // Element width codes
    localparam logic [VRED_SEW_W-1:0] VRED_SEW8  = 2'd0;
    localparam logic [VRED_SEW_W-1:0] VRED_SEW16 = 2'd1;
    localparam logic [VRED_SEW_W-1:0] VRED_SEW32 = 2'd2;
    localparam logic [VRED_SEW_W-1:0] VRED_SEW64 = 2'd3;

    // Control that travels alongside each beat through the pipeline
    typedef struct packed {
        logic                    valid;
        logic                    start;
        logic                    fin;
        logic [VRED_OPSEL_W-1:0] op;
        logic [VRED_SEW_W-1:0]   sew;
    } vred_tag_t;

    // All-ones mask covering one element at the given width
    function automatic logic [63:0] vred_sew_ones(input logic [VRED_SEW_W-1:0] sew);
        logic [63:0] ones;
        case (sew)
            VRED_SEW8:  ones = 64'h0000_0000_0000_00FF;
            VRED_SEW16: ones = 64'h0000_0000_0000_FFFF;
            VRED_SEW32: ones = 64'h0000_0000_FFFF_FFFF;
            default:    ones = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return ones;
    endfunction

    // Identity element of op at the given width, zero-extended to 64 bits
    function automatic logic [63:0] vred_identity(input logic [VRED_OPSEL_W-1:0] op,
                                                  input logic [VRED_SEW_W-1:0]   sew);
        logic [63:0] ones;
        logic [63:0] id;
        ones = vred_sew_ones(sew);
        case (op)
            VRED_AND, VRED_MINU: id = ones;
            VRED_MIN:            id = ones >> 1;             // most-positive signed
            VRED_MAX:            id = ones & ~(ones >> 1);   // most-negative signed
            default:             id = '0;                    // sum, or, xor, maxu
        endcase
        return id;
    endfunction

endpackage

// File: rtl/vred_lane_op.sv
// Combinational lane-wise reduction op of two WIDTH-bit vectors at a runtime element width.
module vred_lane_op
    import vred_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [VRED_OPSEL_W-1:0] op,
    input  logic [VRED_SEW_W-1:0]   sew,
    output logic [WIDTH-1:0]        y
);

    // One result vector per element width; widths wider than the vector yield zero
    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int unsigned EW = 8 << s;
        logic [WIDTH-1:0] r;

        if (EW <= WIDTH) begin : g_on
            for (genvar l = 0; l < WIDTH / EW; l++) begin : g_lane
                logic [EW-1:0] x;
                logic [EW-1:0] z;
                logic [EW-1:0] res;
                logic          lt_u;
                logic          lt_s;

                assign x    = a[l*EW +: EW];
                assign z    = b[l*EW +: EW];
                assign lt_u = x < z;
                assign lt_s = $signed(x) < $signed(z);

                // Per-element operation
                always_comb begin
                    case (op)
                        VRED_SUM:  res = x + z;
                        VRED_MINU: res = lt_u ? x : z;
                        VRED_MIN:  res = lt_s ? x : z;
                        VRED_MAXU: res = lt_u ? z : x;
                        VRED_MAX:  res = lt_s ? z : x;
                        VRED_AND:  res = x & z;
                        VRED_OR:   res = x | z;
                        default:   res = x ^ z;
                    endcase
                end

                assign r[l*EW +: EW] = res;
            end
        end else begin : g_off
            assign r = '0;
        end
    end

    // Pick the result computed at the requested element width
    always_comb begin
        case (sew)
            VRED_SEW8:  y = g_sew[0].r;
            VRED_SEW16: y = g_sew[1].r;
            VRED_SEW32: y = g_sew[2].r;
            default:    y = g_sew[3].r;
        endcase
    end

endmodule

// File: rtl/vred_reduce_tree.sv
// Multi-beat vector reduction: masked input stage, halving tree, accumulator, output register.
module vred_reduce_tree
    import vred_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH = 3,
    parameter int unsigned SEW_WIDTH   = 2,
    parameter int unsigned MASK_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_vec0,
    input  logic [DATA_WIDTH-1:0]  in_vec1,
    input  logic [MASK_WIDTH-1:0]  in_mask,
    input  logic                   in_valid,
    input  logic                   in_start,
    input  logic                   in_end,
    input  logic [OPSEL_WIDTH-1:0] in_opSel,
    input  logic [SEW_WIDTH-1:0]   in_sew,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    output logic [DATA_WIDTH-1:0]  out_vec,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_valid
);

    localparam int unsigned LEVELS = $clog2(DATA_WIDTH / 8);

    logic [VRED_OPSEL_W-1:0] in_op;
    logic [VRED_SEW_W-1:0]   in_sew_c;
    logic [63:0]             ident;
    logic [63:0]             ident_pat;
    logic [DATA_WIDTH-1:0]   ident_rep;
    logic [DATA_WIDTH-1:0]   elem_en;
    logic [DATA_WIDTH-1:0]   masked;

    assign in_op    = in_opSel[VRED_OPSEL_W-1:0];
    assign in_sew_c = in_sew[VRED_SEW_W-1:0];

    // Expand element mask bits to a per-bit enable at the current element width
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_en
        assign elem_en[j] = (in_sew_c == VRED_SEW8)  ? in_mask[j / 8]  :
                            (in_sew_c == VRED_SEW16) ? in_mask[j / 16] :
                            (in_sew_c == VRED_SEW32) ? in_mask[j / 32] :
                                                       in_mask[j / 64];
    end

    // Replace masked-off elements with the op identity so they cannot affect the result
    always_comb begin
        ident = vred_identity(in_op, in_sew_c);
        case (in_sew_c)
            VRED_SEW8:  ident_pat = {8{ident[7:0]}};
            VRED_SEW16: ident_pat = {4{ident[15:0]}};
            VRED_SEW32: ident_pat = {2{ident[31:0]}};
            default:    ident_pat = ident;
        endcase
        ident_rep = {(DATA_WIDTH / 64){ident_pat}};
        masked    = (in_vec0 & elem_en) | (ident_rep & ~elem_en);
    end

    // Index 0 is the input register, index k the output of tree level k
    vred_tag_t             tag_q  [LEVELS+1];
    logic [DATA_WIDTH-1:0] data_q [LEVELS+1];
    logic [63:0]           seed_q [LEVELS+1];
    logic [ADDR_WIDTH-1:0] addr_q [LEVELS+1];
    logic [DATA_WIDTH-1:0] lvl_out [LEVELS];

    // Tree level k folds the upper half of its input onto the lower half
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int unsigned HW = DATA_WIDTH >> k;
        logic [HW-1:0] comb;
        logic          fits;

        vred_lane_op #(
            .WIDTH (HW)
        ) u_lane_op (
            .a   (data_q[k-1][2*HW-1:HW]),
            .b   (data_q[k-1][HW-1:0]),
            .op  (tag_q[k-1].op),
            .sew (tag_q[k-1].sew),
            .y   (comb)
        );

        // Once the halves are narrower than one element the reduced value is already in place
        assign fits           = (32'd8 << tag_q[k-1].sew) <= HW;
        assign lvl_out[k-1]   = fits ? {{(DATA_WIDTH - HW){1'b0}}, comb} : data_q[k-1];
    end

    // Input capture (bubbles carry cleared tags) and tree pipeline registers
    always_ff @(posedge clk) begin
        if (rst || !in_valid) begin
            tag_q[0]  <= '0;
            data_q[0] <= '0;
            seed_q[0] <= '0;
            addr_q[0] <= '0;
        end else begin
            tag_q[0]  <= '{valid: 1'b1, start: in_start, fin: in_end, op: in_op, sew: in_sew_c};
            data_q[0] <= masked;
            seed_q[0] <= in_vec1[63:0];
            addr_q[0] <= in_addr;
        end
        for (int k = 1; k <= LEVELS; k++) begin
            if (rst) begin
                tag_q[k]  <= '0;
                data_q[k] <= '0;
                seed_q[k] <= '0;
                addr_q[k] <= '0;
            end else begin
                tag_q[k]  <= tag_q[k-1];
                data_q[k] <= lvl_out[k-1];
                seed_q[k] <= seed_q[k-1];
                addr_q[k] <= addr_q[k-1];
            end
        end
    end

    vred_tag_t             last_tag;
    logic [63:0]           tree_res;
    logic [63:0]           acc_q;
    logic [63:0]           acc_a;
    logic [63:0]           acc_res;
    logic                  acc_end_q;
    logic [VRED_SEW_W-1:0] acc_sew_q;
    logic [ADDR_WIDTH-1:0] acc_addr_q;

    assign last_tag = tag_q[LEVELS];
    assign tree_res = data_q[LEVELS][63:0];
    // A start beat folds into its seed, discarding any unfinished reduction
    assign acc_a    = last_tag.start ? seed_q[LEVELS] : acc_q;

    vred_lane_op #(
        .WIDTH (64)
    ) u_acc_op (
        .a   (acc_a),
        .b   (tree_res),
        .op  (last_tag.op),
        .sew (last_tag.sew),
        .y   (acc_res)
    );

    // Accumulate valid beats; bubbles hold the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            acc_end_q  <= 1'b0;
            acc_sew_q  <= '0;
            acc_addr_q <= '0;
        end else begin
            acc_end_q  <= last_tag.valid & last_tag.fin;
            acc_sew_q  <= last_tag.sew;
            acc_addr_q <= addr_q[LEVELS];
            if (last_tag.valid) begin
                acc_q <= acc_res;
            end
        end
    end

    logic [DATA_WIDTH-1:0] out_vec_d;

    // Final result trimmed to one element, zero when no reduction completes
    always_comb begin
        out_vec_d = '0;
        if (acc_end_q) begin
            out_vec_d[63:0] = acc_q & vred_sew_ones(acc_sew_q);
        end
    end

    // Output register: one-cycle strobe per completed reduction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_addr  <= '0;
        end else begin
            out_valid <= acc_end_q;
            out_vec   <= out_vec_d;
            if (acc_end_q) begin
                out_addr <= acc_addr_q;
            end
        end
    end

endmodule
